// File: rtl/uart_pkg.sv
// Shared definitions for the UART RX/TX stages: FSM state encoding,
// default frame parameters and a counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int unsigned DEF_CLOCKS_PER_PULSE = 16;
    localparam int unsigned DEF_BITS_PER_WORD    = 8;

    // Width of a counter that must hold the values 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready byte stream between the UART receiver and its consumer.
interface uart_rx_stream_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_stream_sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
    parameter int unsigned         WIDTH     = 1,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values: each stage simply takes the previous one.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages load the reset value so the output is defined from reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: synchronizes rx, samples each bit at mid-bit, rejects
// start glitches, flags framing errors / overruns and presents received
// words on a one-entry valid/ready output buffer.
// CLOCKS_PER_PULSE must be even and >= 4.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = DEF_BITS_PER_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    uart_rx_stream_if.master  m,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CW = cnt_width(CLOCKS_PER_PULSE);
    localparam int unsigned BW = cnt_width(BITS_PER_WORD);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);

    logic rx_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_e              state_d, state_q;
    logic [CW-1:0]            cnt_d, cnt_q;
    logic [BW-1:0]            bit_d, bit_q;
    logic [BITS_PER_WORD-1:0] shreg_d, shreg_q;
    logic [BITS_PER_WORD-1:0] data_d, data_q;
    logic                     valid_d, valid_q;
    logic                     busy_d, busy_q;
    logic                     fe_d, fe_q;
    logic                     ov_d, ov_q;
    logic                     deliver;

    // Next-state logic for the FSM, counters and output buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        deliver = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[bit_q] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit leaves half a bit to re-arm for
                // a back-to-back start bit.
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Output buffer: a handshake frees the slot on the same edge a new
        // word may be loaded, so only a held, unaccepted word causes overrun.
        if (valid_q && m.m_ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || m.m_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign m.m_data  = data_q;
    assign m.m_valid = valid_q;
    assign busy      = busy_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- UART receiver stage feeding the matrix-vector-multiply UART system: converts the serial `rx` line into a byte stream with a valid/ready handshake.
- Synchronizes the asynchronous `rx` pin and samples each bit at mid-bit.
- Rejects start-bit glitches, detects framing errors and overruns.
- Holds one received word in an output register until the consumer accepts it.

Parameters:
- CLOCKS_PER_PULSE, 16, clock cycles per UART bit. Must be even and >= 4.
- BITS_PER_WORD, 8, data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  reset. Synchronous, active-high.
- rx  input  1  asynchronous serial line. Idles high.
- m_data  output  BITS_PER_WORD  received word
- m_valid  output  1  m_data holds an unconsumed word
- m_ready  input  1  consumer accepts the word when m_valid && m_ready
- busy  output  1  high in every state except IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: a completed word was dropped because the buffer was full

Behaviour:
- **Clock and reset:** one clock domain (clk); synchronous active-high reset (rst).
- **Reset values:**
  - m_data=0, m_valid=0, busy=0, frame_err=0, overrun=0.
  - FSM=IDLE, bit counter=0, sample counter=0.
  - Both synchronizer flops set to 1.
- **Reset mid-frame:** abandons the frame with no valid and no error pulse. It also clears any held, unconsumed word.
- **Synchronizer:**
  - rx passes through 2 flops to give rx_s.
  - All decisions use rx_s only.
  - Adds 2 cycles of latency.
- **Sample counter:** runs 0..CLOCKS_PER_PULSE-1 and is cleared on every state change.
- **FSM states and transitions:**
  - IDLE: if rx_s==0, go to START with counter=0.
  - START: at count==CLOCKS_PER_PULSE/2-1 (mid start bit):
    - rx_s==0 → DATA, counter=0, bit index=0.
    - rx_s==1 → glitch; return to IDLE with no pulse.
  - DATA:
    - At count==CLOCKS_PER_PULSE-1 (mid-bit), shift rx_s into the shift register at bit index; index++.
    - After the bit at index BITS_PER_WORD-1 → STOP.
  - STOP: at count==CLOCKS_PER_PULSE-1:
    - rx_s==1: deliver the word (see buffer rules) and go to IDLE immediately, mid stop bit. This allows back-to-back frames.
    - rx_s==0: pulse frame_err, discard the word, go to BREAK.
  - BREAK: remain until rx_s==1, then go to IDLE. A line held low never generates a spurious frame.
- **Output buffer (one entry):**
  - Handshake: m_valid && m_ready clears m_valid on the next edge.
  - Delivery into an empty buffer: m_data<=word and m_valid<=1 on the same edge.
  - Delivery while m_valid==1 and m_ready==0: the new word is dropped, m_data is unchanged and overrun pulses for one cycle.
  - Delivery on the same cycle as a handshake (m_valid && m_ready): the new word is loaded, m_valid stays 1 and there is no overrun.
  - m_data must stay stable while m_valid && !m_ready.
- **Latency:** rx falling edge to m_valid is 2 + CLOCKS_PER_PULSE/2 + (BITS_PER_WORD+1)·CLOCKS_PER_PULSE cycles, ±1. With defaults this is 154±1.
- **Flag outputs:** frame_err and overrun are registered, and never high for more than one cycle per event.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, STOP, BREAK) and width helper $clog2 constants for the counters. The matching TX stage shares this package.
- One sub-module, sync_2ff: generic 2-flop synchronizer with a reset value parameter, instantiated here with reset value 1.
- Counters, FSM and output buffer stay in uart_rx_stream.

Test Plan:
- Reset: rst=1 for 3 cycles with rx=1 → all outputs 0. Releasing rst with rx=1 for 100 cycles → m_valid and busy stay 0.
- Single byte: send 0xA5 (8N1, 16 clk/bit), m_ready=1 → m_valid high one cycle, m_data=0xA5, 154±1 cycles after the rx falling edge. busy drops before the stop bit ends.
- Glitch rejection: rx low for 4 cycles, then high → busy pulses, then 0. No m_valid, frame_err or overrun.
- Framing error: send 0x3C with the stop bit driven 0, then rx held 0 for 50 cycles, then 1 → one frame_err pulse and no m_valid. Busy stays high until rx_s returns high. A following 0x7E is received correctly.
- Overrun and back-to-back:
  - Setup: m_ready=0; send 0x11 then 0x22 back-to-back.
  - Expected: m_data=0x11 stable, one overrun pulse at the 0x22 stop sample.
  - Then m_ready=1 → 0x11 consumed and m_valid=0.
  - Repeat with m_ready=1 throughout → 0x11 then 0x22 delivered, no overrun.
- Reset mid-frame: pulse rst during DATA bit 3 of 0xFF → no m_valid or flags. The next frame 0x5A is received correctly.
